// File: rtl/lutram_dp_bist.sv
// Self-test for a dual-port LUT RAM: clear with ~pat, write pat, verify both read
// ports (SPO at a, DPO at a+DPRA_OFFSET), with optional single-bit fault injection.
module lutram_dp_bist #(
  parameter int A_WIDTH     = 6,
  parameter int D_WIDTH     = 4,
  parameter int ERR_W       = 8,
  parameter int DPRA_OFFSET = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               step_i,
  input  logic [1:0]         mode_i,
  input  logic               fault_en_i,
  input  logic [A_WIDTH-1:0] fault_addr_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               pass_o,
  output logic [ERR_W-1:0]   err_count_o,
  output logic [A_WIDTH-1:0] first_err_addr_o,
  output logic [D_WIDTH-1:0] spo_o,
  output logic [D_WIDTH-1:0] dpo_o
);
  localparam int DEPTH = 2**A_WIDTH;
  localparam int XW    = (A_WIDTH > D_WIDTH) ? A_WIDTH : D_WIDTH;
  localparam int EW1   = ERR_W + 1;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  typedef enum logic [2:0] {IDLE, CLEAR, WRITE, VERIFY, FINISH} state_e;

  state_e             state_q;
  logic [A_WIDTH-1:0] a_q;
  logic [1:0]         mode_q;
  logic               fault_en_q;
  logic [A_WIDTH-1:0] fault_addr_q;
  logic [ERR_W-1:0]   err_q;
  logic [A_WIDTH-1:0] ferr_q;
  logic [D_WIDTH-1:0] mem_q [DEPTH];

  function automatic logic [D_WIDTH-1:0] pat(input logic [1:0] m, input logic [A_WIDTH-1:0] x);
    logic [D_WIDTH-1:0] r;
    logic [XW-1:0]      xe;
    r = '0;
    case (m)
      2'b00: begin
        xe = XW'(x);
        r  = xe[D_WIDTH-1:0];
      end
      2'b01: for (int i = 0; i < D_WIDTH; i++) r[i] = (i % 2 == 0) ^ x[0];
      2'b10: r = D_WIDTH'(1) << (int'(x) % D_WIDTH);
      default: begin
        xe = XW'(~x);
        r  = xe[D_WIDTH-1:0];
      end
    endcase
    return r;
  endfunction

  logic [A_WIDTH-1:0] dpra;
  logic               last;
  logic               we;
  logic [D_WIDTH-1:0] wdata;
  logic               spo_mis, dpo_mis;
  logic [1:0]         inc;
  logic [EW1-1:0]     err_sum;
  logic [ERR_W-1:0]   err_sat;

  assign dpra    = a_q + A_WIDTH'(DPRA_OFFSET);
  assign last    = &a_q;
  assign spo_o   = mem_q[a_q];
  assign dpo_o   = mem_q[dpra];
  assign we      = step_i && !rst && (state_q == CLEAR || state_q == WRITE);
  assign wdata   = (state_q == CLEAR) ? ~pat(mode_q, a_q)
                 : pat(mode_q, a_q) ^ D_WIDTH'(fault_en_q && a_q == fault_addr_q);
  assign spo_mis = spo_o != pat(mode_q, a_q);
  assign dpo_mis = dpo_o != pat(mode_q, dpra);
  assign inc     = {1'b0, spo_mis} + {1'b0, dpo_mis};
  assign err_sum = {1'b0, err_q} + EW1'(inc);
  assign err_sat = (err_sum > {1'b0, ERR_MAX}) ? ERR_MAX : err_sum[ERR_W-1:0];

  always_ff @(posedge clk) begin
    if (we) mem_q[a_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      a_q          <= '0;
      mode_q       <= '0;
      fault_en_q   <= 1'b0;
      fault_addr_q <= '0;
      err_q        <= '0;
      ferr_q       <= '0;
    end else begin
      case (state_q)
        IDLE, FINISH: if (start_i) begin
          state_q      <= CLEAR;
          a_q          <= '0;
          err_q        <= '0;
          ferr_q       <= '0;
          mode_q       <= mode_i;
          fault_en_q   <= fault_en_i;
          fault_addr_q <= fault_addr_i;
        end
        CLEAR, WRITE: if (step_i) begin
          a_q <= a_q + 1'b1;
          if (last) state_q <= (state_q == CLEAR) ? WRITE : VERIFY;
        end
        VERIFY: if (step_i) begin
          a_q   <= a_q + 1'b1;
          err_q <= err_sat;
          // Only the first mismatching step records an address; SPO wins a tie.
          if (err_q == '0 && (spo_mis || dpo_mis)) ferr_q <= spo_mis ? a_q : dpra;
          if (last) state_q <= FINISH;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o           = (state_q == CLEAR) || (state_q == WRITE) || (state_q == VERIFY);
  assign done_o           = (state_q == FINISH);
  assign pass_o           = done_o && (err_q == '0);
  assign err_count_o      = err_q;
  assign first_err_addr_o = ferr_q;
endmodule

// File: tb/tb_lutram_dp_bist.sv
// Randomised bench for lutram_dp_bist: a step-counting array model predicts RAM
// contents and results; a second instance with ERR_W=1 exercises saturation.
module tb_lutram_dp_bist;
  localparam int A = 6, D = 4, DEPTH = 64, TOTAL = 3 * DEPTH;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, step = 1'b0, fen = 1'b0;
  logic [1:0] mode = '0;
  logic [A-1:0] faddr = '0;
  logic busy, done, pass, busy1, done1, pass1;
  logic [7:0] err;
  logic [0:0] err1;
  logic [A-1:0] ferr, ferr1;
  logic [D-1:0] spo, dpo, spo1, dpo1;

  lutram_dp_bist u_dut (
    .clk(clk), .rst(rst), .start_i(start), .step_i(step), .mode_i(mode),
    .fault_en_i(fen), .fault_addr_i(faddr), .busy_o(busy), .done_o(done),
    .pass_o(pass), .err_count_o(err), .first_err_addr_o(ferr), .spo_o(spo), .dpo_o(dpo));

  lutram_dp_bist #(.ERR_W(1)) u_dut_e1 (
    .clk(clk), .rst(rst), .start_i(start), .step_i(step), .mode_i(mode),
    .fault_en_i(fen), .fault_addr_i(faddr), .busy_o(busy1), .done_o(done1),
    .pass_o(pass1), .err_count_o(err1), .first_err_addr_o(ferr1), .spo_o(spo1), .dpo_o(dpo1));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: progress is just a count of accepted steps since start.
  int  mmem [DEPTH];
  bit  mknown [DEPTH];
  bit  m_run, m_fin, m_fen;
  int  m_s, m_err, m_err1, m_ferr, m_mode, m_faddr;
  int  busy_cnt;

  function automatic int mpat(input int m, input int x);
    case (m)
      0: return x % 16;
      1: return (x % 2 == 1) ? 4'b1010 : 4'b0101;
      2: return 1 << (x % D);
      default: return (~x & (DEPTH - 1)) % 16;
    endcase
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_run = 0; m_fin = 0; m_s = 0; m_err = 0; m_err1 = 0; m_ferr = 0;
      m_mode = 0; m_fen = 0; m_faddr = 0;
    end else if (!m_run && start) begin
      m_run = 1; m_fin = 0; m_s = 0; m_err = 0; m_err1 = 0; m_ferr = 0;
      m_mode = int'(mode); m_fen = fen; m_faddr = int'(faddr);
    end else if (m_run && step) begin
      int ph, ad, da, k;
      bit sm, dm;
      ph = m_s / DEPTH;
      ad = m_s % DEPTH;
      if (ph == 0) begin
        mmem[ad] = ~mpat(m_mode, ad) & 15;
        mknown[ad] = 1;
      end else if (ph == 1) begin
        mmem[ad] = mpat(m_mode, ad) ^ ((m_fen && ad == m_faddr) ? 1 : 0);
      end else begin
        da = (ad + 1) % DEPTH;
        sm = mmem[ad] != mpat(m_mode, ad);
        dm = mmem[da] != mpat(m_mode, da);
        k = int'(sm) + int'(dm);
        if (k > 0 && m_err == 0) m_ferr = sm ? ad : da;
        m_err  = (m_err + k > 255) ? 255 : m_err + k;
        m_err1 = (m_err1 + k > 1) ? 1 : m_err1 + k;
      end
      m_s++;
      if (m_s == TOTAL) begin m_run = 0; m_fin = 1; end
    end
  endtask

  task automatic check_outputs();
    int ma, md;
    chk("busy", busy, m_run);
    chk("done", done, m_fin);
    chk("pass", pass, m_fin && m_err == 0);
    chk("err", err, m_err);
    chk("first_err", ferr, m_ferr);
    chk("busy_e1", busy1, m_run);
    chk("err_e1", err1, m_err1);
    chk("pass_e1", pass1, m_fin && m_err1 == 0);
    chk("first_err_e1", ferr1, m_ferr);
    ma = m_run ? m_s % DEPTH : 0;
    md = (ma + 1) % DEPTH;
    if (mknown[ma]) begin
      chk("spo", spo, mmem[ma]);
      chk("spo_e1", spo1, mmem[ma]);
    end
    if (mknown[md]) chk("dpo", dpo, mmem[md]);
    if (busy) busy_cnt++;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  // smode: 0 step every cycle, 1 every 4th cycle, 2 random ~60%
  task automatic run(input logic [1:0] md, input bit fe, input int fa, input int smode,
                     input int exp_busy, input int rst_at, input int st_at);
    int cyc;
    cyc = 0;
    busy_cnt = 0;
    mode = md; fen = fe; faddr = A'(fa); start = 1; step = 0;
    cycle();
    start = 0;
    mode = 2'($urandom); fen = 1'($urandom); faddr = A'($urandom);
    while (cyc < 4000) begin
      case (smode)
        0: step = 1;
        1: step = (cyc % 4 == 3);
        default: step = ($urandom_range(0, 99) < 60);
      endcase
      rst   = (cyc == rst_at);
      start = (cyc == st_at);
      cycle();
      cyc++;
      if (!m_run) break;
    end
    rst = 0; start = 0; step = 0;
    if (cyc >= 4000) chk("timeout", 1, 0);
    if (exp_busy >= 0) chk("busy_cycles", busy_cnt, exp_busy);
  endtask

  initial begin
    repeat (3) cycle();
    rst = 0;
    cycle();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err, 0);
    chk("rst_first_err", ferr, 0);

    run(2'b00, 0, 0, 0, 192, -1, -1);
    chk("m0_done", done, 1);
    chk("m0_pass", pass, 1);
    chk("m0_err", err, 0);

    run(2'b10, 0, 0, 1, 768, -1, -1);
    chk("m2_slow_pass", pass, 1);

    run(2'b01, 1, 10, 0, 192, -1, -1);
    chk("f10_err", err, 2);
    chk("f10_first", ferr, 10);
    chk("f10_pass", pass, 0);

    run(2'b00, 1, 0, 0, 192, -1, -1);
    chk("f0_err", err, 2);
    chk("f0_first", ferr, 0);
    chk("f0_pass", pass, 0);

    for (int m = 0; m < 4; m++) begin
      run(2'(m), 1, int'($urandom_range(0, DEPTH - 1)), 2, -1, -1, -1);
      chk("sat_err_e1", err1, 1);
      chk("sat_err", err, 2);
    end

    // Restart straight from FINISH without a fault.
    run(2'b11, 0, 0, 0, 192, -1, -1);
    chk("restart_pass", pass, 1);
    chk("restart_err", err, 0);

    // Stray start while busy, then reset mid-run.
    run(2'b01, 0, 0, 0, -1, 100, 50);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_err", err, 0);

    run(2'b00, 0, 0, 0, 192, -1, -1);
    chk("post_rst_pass", pass, 1);

    for (int r = 0; r < 3; r++)
      run(2'($urandom), 1'($urandom), int'($urandom_range(0, DEPTH - 1)), 2, -1, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/lutram_dp_bist.md
Name: lutram_dp_bist

Overview:
- Parametrised built-in self-test for a dual-port distributed (LUT) RAM of 2**A_WIDTH x D_WIDTH.
- Clears, writes and verifies the array through both ports: write/SPO port at address a, DPO port at a+DPRA_OFFSET.
- Reports pass/fail, mismatch count and first failing address.
- Sits beside the lutram primitive tests as their generic, self-checking successor. Stepping is gated by an enable strobe, not a derived clock.

Parameters:
- A_WIDTH, 6, address width; DEPTH = 2**A_WIDTH.
- D_WIDTH, 4, data width (>=1).
- ERR_W, 8, error-counter width.
- DPRA_OFFSET, 1, read-port address offset during VERIFY, modulo DEPTH.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start_i  in  1  start pulse; sampled in IDLE or FINISH only.
- step_i  in  1  advance enable; 1 = one address per cycle.
- mode_i  in  2  pattern select, latched on accepted start.
- fault_en_i  in  1  fault injection enable, latched on start.
- fault_addr_i  in  A_WIDTH  injected-fault address, latched on start.
- busy_o  out  1  high in CLEAR/WRITE/VERIFY.
- done_o  out  1  high in FINISH.
- pass_o  out  1  done_o and err_count_o==0.
- err_count_o  out  ERR_W  saturating mismatch count.
- first_err_addr_o  out  A_WIDTH  address of first mismatch.
- spo_o  out  D_WIDTH  raw RAM output at address a (asynchronous read).
- dpo_o  out  D_WIDTH  raw RAM output at DPRA address (asynchronous read).

Behaviour:
- Reset: state IDLE, counter a=0, busy/done/pass=0, err_count=0, first_err_addr=0, latched mode/fault=0. RAM contents are not reset.
- RAM: synchronous write on clk when we=1; asynchronous read on both ports; write port and SPO share address a; DPO address = (a+DPRA_OFFSET) mod DEPTH in all states.
- pat(x), truncated or zero-extended to D_WIDTH:
  - mode 00: x.
  - mode 01: alternating ...0101 XOR {D_WIDTH{x[0]}}.
  - mode 10: one-hot 1<<(x mod D_WIDTH).
  - mode 11: ~x.
- States and transitions:
  - IDLE: start_i -> CLEAR, a=0, err_count=0, first_err_addr=0, latch mode/fault.
  - CLEAR: on step_i, write ~pat(a), a++. Step with a==DEPTH-1 -> WRITE, a=0.
  - WRITE: on step_i, write pat(a), XOR 1 in bit 0 if fault_en and a==fault_addr; a++. Last step -> VERIFY, a=0.
  - VERIFY: on step_i, compare spo vs pat(a) and dpo vs pat(a+DPRA_OFFSET). Each mismatching port adds 1 (0, 1 or 2 per step), saturating at 2**ERR_W-1. Last step -> FINISH.
  - FINISH: done_o=1, results held. start_i -> CLEAR (restart, results cleared).
- first_err_addr: captured on the first mismatching step only. Value is a if SPO mismatches, else the DPO address.
- we = step_i and (CLEAR or WRITE). With step_i=0 nothing changes.
- start_i while busy: ignored. Unknown state encodings -> IDLE.
- Latency:
  - busy_o rises the cycle after start is accepted.
  - With step_i=1, a full run takes 3*DEPTH cycles in CLEAR..VERIFY; done_o rises the next cycle.
  - Results update in the same edge as the compared step.
- rst mid-run: next cycle matches reset values; no further writes.

Test Plan:
- Defaults, mode 00, step_i=1, start pulse -> busy_o high 192 cycles, then done_o=1, pass_o=1, err_count_o=0.
- step_i high every 4th cycle, mode 10 -> done_o after 768 cycles; pass_o=1. RAM and counter frozen on non-step cycles.
- fault_en=1, fault_addr=10, mode 01 -> err_count_o=2, first_err_addr_o=10. DPO mismatch occurs at a=9, address 10.
- fault_en=1, fault_addr=0 (DPO wrap) -> SPO hit at a=0, DPO hit at a=63. err_count_o=2, first_err_addr_o=0, pass_o=0.
- ERR_W=1, all 4 modes with fault -> err_count_o saturates at 1. Back-to-back restart from FINISH clears results, then passes without fault.
- Assert rst at cycle 100 of a run -> all outputs reset next cycle. start_i during busy is ignored; a new start then gives a full 192-cycle passing run.
